// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the neural-net layer control blocks.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

  localparam int ENG_LAT_DEF  = 11;
  localparam int ACT_W        = 16;
  localparam int NEURON_IDX_W = 8;

  typedef logic [NEURON_IDX_W-1:0] neuron_idx_t;

endpackage

// File: rtl/seq_tag_pipe.sv
// Fixed-depth {valid, addr} delay line that tracks each neuron index through
// read + engine latency. Never stalls; flush clears every stage synchronously.
module seq_tag_pipe #(
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pending
);

  localparam logic [DEPTH-1:0] HEAD_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      addr_pipe[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_addr  = addr_pipe[DEPTH-1];
  // Tags still in flight behind the tail; the tail itself is being written now.
  assign pending   = |(vld_pipe & HEAD_MASK);

endmodule

// File: rtl/dot_layer_sequencer.sv
// Sequences one fully-connected layer through the pipelined dot-product engine.
// Optional SEQ_RELU_EN applies ReLU to each result before it is written.
module dot_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int ENG_LAT = ENG_LAT_DEF,
  parameter int DATA_W  = ACT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_neurons,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              eng_run,
  input  logic [DATA_W-1:0] eng_out,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data
);

  localparam int DEPTH = RD_LAT + ENG_LAT;

  seq_state_t        state, state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] issue_cnt;
  logic              last_issue;
  logic              accept;
  logic              cancel;
  logic              pending;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic [DATA_W-1:0] wr_val;

  // abort wins over start in IDLE, so start only counts without it.
  assign accept     = (state == IDLE) && start && !abort;
  assign cancel     = abort && ((state == ISSUE) || (state == DRAIN));
  assign last_issue = ({1'b0, issue_cnt} == (count - (ADDR_W+1)'(1)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (num_neurons == '0) ? DONE : ISSUE;
      ISSUE:   if (abort) state_nxt = IDLE;
               else if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (!pending) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count     <= num_neurons;
        issue_cnt <= '0;
      end else if ((state == ISSUE) && !last_issue) begin
        // Held at the last address so a full 2**ADDR_W layer never wraps.
        issue_cnt <= issue_cnt + ADDR_W'(1);
      end
    end
  end

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign eng_run   = busy;
  assign done      = (state == DONE);
  assign w_rd_en   = (state == ISSUE);
  assign w_rd_addr = w_rd_en ? issue_cnt : '0;

  seq_tag_pipe #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk       (clk),
    .flush     (reset || cancel),
    .in_valid  (w_rd_en),
    .in_addr   (w_rd_addr),
    .out_valid (tag_valid),
    .out_addr  (tag_addr),
    .pending   (pending)
  );

`ifdef SEQ_RELU_EN
  assign wr_val = eng_out[DATA_W-1] ? '0 : eng_out;
`else
  assign wr_val = eng_out;
`endif

  assign res_wr_en   = tag_valid;
  assign res_wr_addr = tag_addr;
  assign res_wr_data = tag_valid ? wr_val : '0;

endmodule
